// File: rtl/keypad_pkg.sv
// Shared types and the Pmod KYPD key map for the keypad scanner slice.
// The optional auto-repeat feature is enabled with KYPD_AUTOREPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_ONE,
        RES_MULTI
    } scan_res_e;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } deb_state_e;

    // Indexed by {col, row}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

endpackage

// File: rtl/keypad_debouncer.sv
// Debounces per-scan keypad results into a held key code with press/release strobes.
// Auto-repeat of key_press while held is enabled with KYPD_AUTOREPEAT_EN.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 125,
    parameter int REPEAT_RATE_SCANS  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done,
    input  scan_res_e  scan_kind,
    input  logic [3:0] scan_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] STABLE = DW'(DEBOUNCE_SCANS);

    deb_state_e      state, state_n;
    scan_res_e       prev_kind, prev_kind_n;
    logic [3:0]      prev_code, prev_code_n;
    logic [3:0]      code_n;
    logic [DW-1:0]   stab, stab_n;
    logic            press_n, release_n;

    if (DEBOUNCE_SCANS < 1 || REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_bad_params
    end

`ifdef KYPD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt, rpt_n, rpt_target;
    logic          repeating, repeating_n;
`endif

    assign key_valid = (state == ST_HELD);

    always_comb begin
        state_n     = state;
        code_n      = key_code;
        prev_kind_n = prev_kind;
        prev_code_n = prev_code;
        stab_n      = stab;
        press_n     = 1'b0;
        release_n   = 1'b0;
        if (scan_done) begin
            prev_kind_n = scan_kind;
            prev_code_n = scan_code;
            if (scan_kind == RES_MULTI) begin
                stab_n = '0;
            end else begin
                if (scan_kind == prev_kind && (scan_kind == RES_NONE || scan_code == prev_code))
                    stab_n = (stab >= STABLE) ? STABLE : stab + DW'(1);
                else
                    stab_n = DW'(1);
                if (stab_n >= STABLE) begin
                    case (state)
                        ST_IDLE: begin
                            if (scan_kind == RES_ONE) begin
                                state_n = ST_HELD;
                                code_n  = scan_code;
                                press_n = 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (scan_kind == RES_NONE) begin
                                state_n   = ST_IDLE;
                                release_n = 1'b1;
                            end else if (scan_code != key_code) begin
                                code_n    = scan_code;
                                press_n   = 1'b1;
                                release_n = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
`ifdef KYPD_AUTOREPEAT_EN
        rpt_n       = rpt;
        repeating_n = repeating;
        rpt_target  = repeating ? RW'(REPEAT_RATE_SCANS) : RW'(REPEAT_DELAY_SCANS);
        // Any transition (entry, roll-over, release) restarts the delay phase
        if (state != ST_HELD || press_n || release_n) begin
            rpt_n       = '0;
            repeating_n = 1'b0;
        end else if (scan_done) begin
            if (rpt + RW'(1) == rpt_target) begin
                rpt_n       = '0;
                repeating_n = 1'b1;
                press_n     = 1'b1;
            end else begin
                rpt_n = rpt + RW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            key_code    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            prev_kind   <= RES_NONE;
            prev_code   <= '0;
            stab        <= '0;
`ifdef KYPD_AUTOREPEAT_EN
            rpt         <= '0;
            repeating   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            key_code    <= code_n;
            key_press   <= press_n;
            key_release <= release_n;
            prev_kind   <= prev_kind_n;
            prev_code   <= prev_code_n;
            stab        <= stab_n;
`ifdef KYPD_AUTOREPEAT_EN
            rpt         <= rpt_n;
            repeating   <= repeating_n;
`endif
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Pmod KYPD 4x4 column scanner: synchronizes rows, accumulates one result per full scan
// and hands it to the debouncer. Auto-repeat is enabled with KYPD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES        = 100000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 125,
    parameter int REPEAT_RATE_SCANS  = 25
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col_out,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release
);

    localparam int CW = $clog2(SCAN_CYCLES);

    logic [3:0]    row_meta, row_sync;
    logic [CW-1:0] cyc;
    logic [1:0]    col;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic          window_end, scan_done;
    logic [3:0]    row_low;
    logic [2:0]    col_hits, total_hits;
    logic [1:0]    hit_row;
    logic [3:0]    scan_code;
    scan_res_e     scan_kind;

    assign window_end = (cyc == CW'(SCAN_CYCLES - 1));
    assign scan_done  = window_end && (col == 2'd3);

    // acc_cnt saturates at 2: beyond that the scan is MULTI regardless
    always_comb begin
        row_low  = ~row_sync;
        col_hits = '0;
        hit_row  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (row_low[i]) begin
                col_hits = col_hits + 3'd1;
                hit_row  = 2'(i);
            end
        end
        total_hits = {1'b0, acc_cnt} + col_hits;
        scan_code  = (acc_cnt == 2'd0) ? KEY_MAP[{col, hit_row}] : acc_code;
        if (total_hits == 3'd0)
            scan_kind = RES_NONE;
        else if (total_hits == 3'd1)
            scan_kind = RES_ONE;
        else
            scan_kind = RES_MULTI;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
            cyc      <= '0;
            col      <= '0;
            col_out  <= 4'b1110;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            if (window_end) begin
                cyc     <= '0;
                col     <= col + 2'd1;
                col_out <= {col_out[2:0], col_out[3]};
                if (col == 2'd3) begin
                    acc_cnt  <= '0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= (total_hits > 3'd1) ? 2'd2 : total_hits[1:0];
                    acc_code <= scan_code;
                end
            end else begin
                cyc <= cyc + CW'(1);
            end
        end
    end

    keypad_debouncer #(
        .DEBOUNCE_SCANS     (DEBOUNCE_SCANS),
        .REPEAT_DELAY_SCANS (REPEAT_DELAY_SCANS),
        .REPEAT_RATE_SCANS  (REPEAT_RATE_SCANS)
    ) u_debouncer (
        .clk         (clk),
        .reset       (reset),
        .scan_done   (scan_done),
        .scan_kind   (scan_kind),
        .scan_code   (scan_code),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_press   (key_press),
        .key_release (key_release)
    );

endmodule
